// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: NOP encoding, default reset PC and
// the width helper used for queue occupancy counters.
package fetch_pkg;

    // Instruction word presented to decode whenever nothing valid is available.
    localparam int NOP_INSTR      = 0;
    // Default program counter fetched first after reset.
    localparam int FETCH_RESET_PC = 0;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous show-ahead FIFO with clear. Pointers carry one extra wrap bit so
// full and empty are told apart without a separate counter register.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [occ_width(DEPTH)-1:0]  count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      fill;
    logic             full;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem [DEPTH];

    assign fill    = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = CW'(fill);
    assign do_pop  = pop && !empty;
    // A full queue may still take a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    // Head is read combinationally so decode sees the entry the cycle it lands.
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clock) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Fetch stage: streams sequential PCs to program memory, pairs each one-cycle
// response with its PC and queues it for decode. Redirect and flush discard
// both queued entries and the response currently returning from memory.
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH     = 12,
    parameter int PMEM_WIDTH   = 16,
    parameter int PC_INCREMENT = 2,
    parameter int DEPTH        = 4,
    parameter int RESET_PC     = FETCH_RESET_PC
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_set_pc,
    input  logic [PC_WIDTH-1:0]          in_new_pc,
    input  logic                         in_flush,
    input  logic                         in_dc_ready,
    input  logic [PMEM_WIDTH-1:0]        in_instr,
    output logic [PC_WIDTH-1:0]          out_pmem_addr,
    output logic                         out_pmem_en,
    output logic                         out_valid,
    output logic [PMEM_WIDTH-1:0]        out_instr,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [occ_width(DEPTH)-1:0]  out_count
);

    localparam int CW = occ_width(DEPTH);
    localparam int EW = PC_WIDTH + PMEM_WIDTH;

    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic [PC_WIDTH-1:0]   last_pc;
    logic                  inflight;
    logic                  discard;
    logic                  push;
    logic                  pop;
    logic [CW:0]           occupancy;
    logic [EW-1:0]         q_head;
    logic [CW-1:0]         q_count;
    logic                  q_empty;
    logic [PC_WIDTH-1:0]   head_pc;
    logic [PMEM_WIDTH-1:0] head_instr;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clock (clock),
        .reset (reset),
        .clear (discard),
        .push  (push),
        .pop   (pop),
        .wdata ({inflight_pc, in_instr}),
        .head  (q_head),
        .count (q_count),
        .empty (q_empty)
    );

    assign head_pc    = q_head[EW-1 -: PC_WIDTH];
    assign head_instr = q_head[PMEM_WIDTH-1:0];
    assign out_count  = q_count;

    // Hand-off to decode, queue control and the issue/redirect address mux.
    always_comb begin
        discard       = in_set_pc || in_flush;
        out_valid     = !q_empty && !discard;
        pop           = out_valid && in_dc_ready;
        push          = inflight && !discard;
        out_instr     = out_valid ? head_instr : PMEM_WIDTH'(NOP_INSTR);
        out_pc        = out_valid ? head_pc : last_pc;
        // Slots already promised: queued entries plus the returning response,
        // minus the one leaving now. Issuing only below DEPTH means every
        // response always finds room.
        occupancy     = {1'b0, q_count} + (CW+1)'(inflight) - (CW+1)'(pop);
        out_pmem_addr = in_set_pc ? in_new_pc : fetch_pc;
        if (reset)          out_pmem_en = 1'b0;
        else if (in_set_pc) out_pmem_en = 1'b1;
        else if (in_flush)  out_pmem_en = 1'b0;
        else                out_pmem_en = (occupancy < (CW+1)'(DEPTH));
    end

    // Fetch pointer, in-flight tracking and the PC shown while decode sees no entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc    <= PC_WIDTH'(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
            last_pc     <= '0;
        end else begin
            if (in_set_pc)        fetch_pc <= in_new_pc + PC_WIDTH'(PC_INCREMENT);
            else if (out_pmem_en) fetch_pc <= fetch_pc + PC_WIDTH'(PC_INCREMENT);
            inflight    <= out_pmem_en;
            inflight_pc <= out_pmem_addr;
            if (out_valid) last_pc <= head_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: a one-cycle pmem model plus a
// transaction-level model (queue of pending PCs) predicting decode traffic.
module tb_fetch_prefetch;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_set_pc = 1'b0;
    logic [11:0] in_new_pc = '0;
    logic        in_flush = 1'b0;
    logic        in_dc_ready = 1'b0;
    logic [15:0] in_instr = '0;
    logic [11:0] out_pmem_addr;
    logic        out_pmem_en;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [11:0] out_pc;
    logic [2:0]  out_count;

    int checks = 0;
    int errors = 0;

    fetch_prefetch dut (
        .clock         (clock),
        .reset         (reset),
        .in_set_pc     (in_set_pc),
        .in_new_pc     (in_new_pc),
        .in_flush      (in_flush),
        .in_dc_ready   (in_dc_ready),
        .in_instr      (in_instr),
        .out_pmem_addr (out_pmem_addr),
        .out_pmem_en   (out_pmem_en),
        .out_valid     (out_valid),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_count     (out_count)
    );

    always #5 clock = ~clock;

    // Program memory contents: never zero, so a NOP is always distinguishable.
    function automatic logic [15:0] pmem_word(input logic [11:0] a);
        return ({4'hC, a} ^ 16'h5A5A) | 16'h0001;
    endfunction

    // Program memory: a request seen in one cycle answers during the next.
    logic        pend_en = 1'b0;
    logic [11:0] pend_addr = '0;
    always @(negedge clock) begin
        pend_en   = out_pmem_en;
        pend_addr = out_pmem_addr;
    end
    always @(posedge clock) begin
        #1;
        in_instr = pend_en ? pmem_word(pend_addr) : 16'hBAD0;
    end

    // Reference model state: PCs fetched but not yet taken by decode.
    logic [11:0] mq[$];
    logic        m_inflight;
    logic [11:0] m_inf_pc;
    logic [11:0] m_fptr;
    logic [11:0] m_last_pc;

    // Expected and observed values for the most recent cycle.
    logic        e_valid, e_en, o_valid, o_en;
    logic [15:0] e_instr, o_instr;
    logic [11:0] e_pc, e_addr, o_pc, o_addr;
    logic [2:0]  e_count, o_count;
    logic [11:0] accepted[$];

    task automatic model_reset();
        mq.delete();
        m_inflight = 1'b0;
        m_inf_pc   = '0;
        m_fptr     = '0;
        m_last_pc  = '0;
        accepted.delete();
    endtask

    // One clock: drive inputs, predict and sample at negedge, advance model.
    task automatic cycle(input bit set, input logic [11:0] npc, input bit fl, input bit rdy);
        bit pop;
        in_set_pc   = set;
        in_new_pc   = npc;
        in_flush    = fl;
        in_dc_ready = rdy;
        @(negedge clock);
        e_count = 3'(mq.size());
        e_valid = (mq.size() > 0) && !set && !fl;
        e_pc    = e_valid ? mq[0] : m_last_pc;
        e_instr = e_valid ? pmem_word(mq[0]) : 16'h0000;
        pop     = e_valid && rdy;
        e_en    = set ? 1'b1 : (fl ? 1'b0 : ((mq.size() + int'(m_inflight) - int'(pop)) < DEPTH));
        e_addr  = set ? npc : m_fptr;
        o_valid = out_valid;
        o_instr = out_instr;
        o_pc    = out_pc;
        o_en    = out_pmem_en;
        o_addr  = out_pmem_addr;
        o_count = out_count;
        if (o_valid && rdy) accepted.push_back(o_pc);
        @(posedge clock);
        if (set || fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (m_inflight) mq.push_back(m_inf_pc);
        end
        if (e_valid) m_last_pc = e_pc;
        m_fptr     = set ? npc + 12'd2 : (e_en ? m_fptr + 12'd2 : m_fptr);
        m_inflight = e_en;
        m_inf_pc   = e_addr;
        #1;
    endtask

    task automatic test_reset();
        #12;
        @(negedge clock);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        checks++; if (out_instr !== 16'h0) begin errors++; $display("FAIL reset_instr got %h want 0000", out_instr); end
        checks++; if (out_pc !== 12'h0) begin errors++; $display("FAIL reset_pc got %h want 000", out_pc); end
        checks++; if (out_pmem_en !== 1'b0) begin errors++; $display("FAIL reset_en got %0b want 0", out_pmem_en); end
        checks++; if (out_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", out_count); end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        $display("reset released");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b1);
            $display("stream cyc %0d en=%0b addr=%h valid=%0b pc=%h", i, o_en, o_addr, o_valid, o_pc);
            checks++; if (o_en !== e_en) begin errors++; $display("FAIL stream_en cyc %0d got %0b want %0b", i, o_en, e_en); end
            if (e_en) begin
                checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL stream_addr cyc %0d got %h want %h", i, o_addr, e_addr); end
            end
            checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL stream_valid cyc %0d got %0b want %0b", i, o_valid, e_valid); end
            checks++; if (o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL stream_head cyc %0d got %h/%h want %h/%h", i, o_pc, o_instr, e_pc, e_instr); end
        end
        // From the third cycle on decode sees one new PC per cycle: 0,2,4,...
        for (int i = 0; i < 6; i++) begin
            checks++; if (accepted[i] !== 12'(2 * i)) begin errors++; $display("FAIL stream_order idx %0d got %h want %h", i, accepted[i], 12'(2 * i)); end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b0);
            $display("stall cyc %0d count=%0d en=%0b", i, o_count, o_en);
            checks++; if (o_count !== e_count || o_en !== e_en) begin errors++; $display("FAIL stall_state cyc %0d got %0d/%0b want %0d/%0b", i, o_count, o_en, e_count, e_en); end
        end
        checks++; if (o_count !== 3'(DEPTH) || o_en !== 1'b0) begin errors++; $display("FAIL stall_full got count %0d en %0b want %0d/0", o_count, o_en, DEPTH); end
        accepted.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b1);
            checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL drain cyc %0d got %0b %h %h want %0b %h %h", i, o_valid, o_pc, o_instr, e_valid, e_pc, e_instr); end
        end
        // Consecutive PCs prove no entry was lost during the stall.
        for (int i = 1; i < accepted.size(); i++) begin
            checks++; if (accepted[i] !== accepted[i-1] + 12'd2) begin errors++; $display("FAIL drain_seq idx %0d got %h want %h", i, accepted[i], accepted[i-1] + 12'd2); end
        end
    endtask

    task automatic test_redirect(input logic [11:0] target, input string tag);
        for (int i = 0; i < 5; i++) cycle(1'b0, 12'h0, 1'b0, 1'b0);
        cycle(1'b1, target, 1'b0, 1'b1);
        $display("%s redirect to %h valid=%0b addr=%h", tag, target, o_valid, o_addr);
        checks++; if (o_valid !== 1'b0 || o_instr !== 16'h0) begin errors++; $display("FAIL %s_valid got %0b/%h want 0/0000", tag, o_valid, o_instr); end
        checks++; if (o_en !== 1'b1 || o_addr !== target) begin errors++; $display("FAIL %s_addr got %0b/%h want 1/%h", tag, o_en, o_addr, target); end
        accepted.delete();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b1);
            checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL %s_follow cyc %0d got %0b %h want %0b %h", tag, i, o_valid, o_pc, e_valid, e_pc); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (accepted[i] !== target + 12'(2 * i)) begin errors++; $display("FAIL %s_seq idx %0d got %h want %h", tag, i, accepted[i], target + 12'(2 * i)); end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 1'b0, 1'b1);
        cycle(1'b0, 12'h0, 1'b1, 1'b1);
        $display("flush valid=%0b instr=%h en=%0b", o_valid, o_instr, o_en);
        checks++; if (o_valid !== 1'b0 || o_instr !== 16'h0 || o_en !== 1'b0) begin errors++; $display("FAIL flush_cycle got %0b/%h/%0b want 0/0000/0", o_valid, o_instr, o_en); end
        cycle(1'b0, 12'h0, 1'b0, 1'b1);
        checks++; if (o_count !== 3'd0 || o_valid !== 1'b0) begin errors++; $display("FAIL flush_after got count %0d valid %0b want 0/0", o_count, o_valid); end
        checks++; if (o_en !== e_en || o_addr !== e_addr) begin errors++; $display("FAIL flush_resume got %0b/%h want %0b/%h", o_en, o_addr, e_en, e_addr); end
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b1);
            checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL flush_follow cyc %0d got %0b %h want %0b %h", i, o_valid, o_pc, e_valid, e_pc); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit set, fl, rdy;
            logic [11:0] npc;
            set = ($urandom_range(0, 19) == 0);
            fl  = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            npc = 12'($urandom_range(0, 2047) * 2);
            cycle(set, npc, fl, rdy);
            $display("rand cyc %0d set=%0b fl=%0b rdy=%0b valid=%0b pc=%h count=%0d en=%0b addr=%h", i, set, fl, rdy, o_valid, o_pc, o_count, o_en, o_addr);
            checks++; if (o_valid !== e_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %0b want %0b", i, o_valid, e_valid); end
            checks++; if (o_pc !== e_pc) begin errors++; $display("FAIL rand_pc cyc %0d got %h want %h", i, o_pc, e_pc); end
            checks++; if (o_instr !== e_instr) begin errors++; $display("FAIL rand_instr cyc %0d got %h want %h", i, o_instr, e_instr); end
            checks++; if (o_count !== e_count) begin errors++; $display("FAIL rand_count cyc %0d got %0d want %0d", i, o_count, e_count); end
            checks++; if (o_en !== e_en) begin errors++; $display("FAIL rand_en cyc %0d got %0b want %0b", i, o_en, e_en); end
            if (e_en) begin
                checks++; if (o_addr !== e_addr) begin errors++; $display("FAIL rand_addr cyc %0d got %h want %h", i, o_addr, e_addr); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) cycle(1'b0, 12'h0, 1'b0, 1'b0);
        checks++; if (o_count !== 3'(DEPTH)) begin errors++; $display("FAIL midrst_prefill got %0d want %0d", o_count, DEPTH); end
        #2;
        reset = 1'b1;
        #1;
        $display("mid reset valid=%0b count=%0d en=%0b", out_valid, out_count, out_pmem_en);
        checks++; if (out_valid !== 1'b0 || out_count !== 3'd0 || out_pmem_en !== 1'b0) begin errors++; $display("FAIL midrst_async got %0b/%0d/%0b want 0/0/0", out_valid, out_count, out_pmem_en); end
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        cycle(1'b0, 12'h0, 1'b0, 1'b1);
        checks++; if (o_en !== 1'b1 || o_addr !== 12'h000) begin errors++; $display("FAIL midrst_refetch got %0b/%h want 1/000", o_en, o_addr); end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 12'h0, 1'b0, 1'b1);
            checks++; if (o_valid !== e_valid || o_pc !== e_pc || o_instr !== e_instr) begin errors++; $display("FAIL midrst_follow cyc %0d got %0b %h want %0b %h", i, o_valid, o_pc, e_valid, e_pc); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect(12'h100, "redir");
        test_flush();
        test_redirect(12'hFFC, "wrap");
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
